// File: rtl/conv_defs_pkg.sv
// Shared constants for the 3x3 convolution path: operand/accumulator widths and
// tap count, shared with the weight address generator so both agree on the kernel.
package conv_defs;

  localparam int DATA_W  = 8;
  localparam int TAPS    = 9;
  localparam int PROD_W  = 2 * DATA_W;
  localparam int ACC_W   = 2 * DATA_W + 4;
  localparam int WADDR_W = $clog2(TAPS);

endpackage : conv_defs

// File: rtl/conv_tap_mult.sv
// Stage 1 of the window MAC: registered signed multiply of one weight/pixel tap,
// with the tap-valid and last-of-window flags carried alongside the product.
module conv_tap_mult
  import conv_defs::*;
#(
  parameter int DW = DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid_i,
  input  logic                   last_i,
  input  logic signed [DW-1:0]   weight_i,
  input  logic signed [DW-1:0]   pixel_i,
  output logic signed [2*DW-1:0] prod_o,
  output logic                   prod_vld_o,
  output logic                   prod_last_o
);

  logic signed [2*DW-1:0] prod_q;
  logic                   prod_vld_q;
  logic                   prod_last_q;
  logic                   take;

  assign take = in_valid_i && !clear;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      prod_last_q <= 1'b0;
    end else begin
      if (take) begin
        prod_q <= weight_i * pixel_i;
      end
      prod_vld_q  <= take;
      prod_last_q <= take && last_i;
    end
  end

  assign prod_o      = prod_q;
  assign prod_vld_o  = prod_vld_q;
  assign prod_last_o = prod_last_q;

endmodule : conv_tap_mult

// File: rtl/conv_window_mac.sv
// 3x3 convolution-window multiply-accumulate: 9 taps in, one window sum out with a
// one-cycle valid pulse. Define CONV_MAC_RELU_EN to clamp negative results to zero.
module conv_window_mac
  import conv_defs::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int TAPS_P   = TAPS,
  parameter int ACC_W_P  = 2 * DATA_W_P + 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic signed [DATA_W_P-1:0] weight_data,
  input  logic signed [DATA_W_P-1:0] pixel_data,
  output logic                       out_valid,
  output logic signed [ACC_W_P-1:0]  out_data,
  output logic                       busy
);

  localparam int CNT_W  = $clog2(TAPS_P);
  localparam int PW     = 2 * DATA_W_P;

  logic [CNT_W-1:0]          tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W_P-1:0] acc_q, acc_d;
  logic                      start_q, start_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [ACC_W_P-1:0] out_data_q, out_data_d;

  logic signed [PW-1:0]      prod;
  logic                      prod_vld;
  logic                      prod_last;
  logic                      tap_last;
  logic signed [ACC_W_P-1:0] sum;

  assign tap_last = (tap_cnt_q == CNT_W'(TAPS_P - 1));

  conv_tap_mult #(.DW(DATA_W_P)) u_mult (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid_i (in_valid),
    .last_i     (tap_last),
    .weight_i   (weight_data),
    .pixel_i    (pixel_data),
    .prod_o     (prod),
    .prod_vld_o (prod_vld),
    .prod_last_o(prod_last)
  );

  // start_q marks that the next product opens a new window, so back-to-back
  // windows restart the sum without an idle cycle.
  assign sum = (start_q ? '0 : acc_q)
             + {{(ACC_W_P - PW){prod[PW-1]}}, prod};

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tap_cnt_d   = tap_cnt_q;
    acc_d       = acc_q;
    start_d     = start_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    if (in_valid) begin
      tap_cnt_d = tap_last ? '0 : tap_cnt_q + CNT_W'(1);
    end

    if (prod_vld) begin
      acc_d   = sum;
      start_d = prod_last;
      if (prod_last) begin
        out_valid_d = 1'b1;
`ifdef CONV_MAC_RELU_EN
        out_data_d  = sum[ACC_W_P-1] ? '0 : sum;
`else
        out_data_d  = sum;
`endif
      end
    end

    if (clear) begin
      tap_cnt_d   = '0;
      acc_d       = '0;
      start_d     = 1'b1;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      start_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // The result register is loaded on the same edge that absorbs the last
  // product, so prod_vld already covers the only pending completion.
  assign busy      = (tap_cnt_q != '0) || prod_vld;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule : conv_window_mac

// File: tb/tb_conv_window_mac.sv
// Self-checking bench for conv_window_mac: a window-level model predicts pulses,
// held result and busy per edge; literal window sums pin the model.
module tb_conv_window_mac;

  localparam int DW = 8;
  localparam int AW = 2 * DW + 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] weight_data = '0;
  logic signed [DW-1:0] pixel_data = '0;
  logic                 out_valid;
  logic signed [AW-1:0] out_data;
  logic                 busy;

  conv_window_mac dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .weight_data(weight_data),
    .pixel_data (pixel_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  bit done = 1'b0;

  // Model output, keyed by the rising edge after which it must be visible.
  int pulse_at [int];
  bit rst_at   [int];
  bit busy_at  [int];
  int got_q [$];

  int m_cnt = 0;
  int m_sum = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
    end
  endtask

  function automatic int relu(input int s);
`ifdef CONV_MAC_RELU_EN
    return (s < 0) ? 0 : s;
`else
    return s;
`endif
  endfunction

  // One clock cycle of stimulus; the model is advanced for the edge it hits.
  task automatic step(input bit r, input bit c, input bit v, input int w, input int p);
    int e;
    e = edge_cnt + 1;
    if (r || c) begin
      m_cnt = 0;
      m_sum = 0;
      pulse_at.delete(e);
      if (r) rst_at[e] = 1'b1;
      busy_at[e] = 1'b0;
    end else begin
      if (v) begin
        m_sum += w * p;
        m_cnt++;
        if (m_cnt == 9) begin
          pulse_at[e + 1] = relu(m_sum);
          m_cnt = 0;
          m_sum = 0;
        end
      end
      busy_at[e] = (m_cnt != 0) || v;
    end
    reset       = r;
    clear       = c;
    in_valid    = v;
    weight_data = DW'(w);
    pixel_data  = DW'(p);
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic tap(input int w, input int p);
    step(1'b0, 1'b0, 1'b1, w, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Compare process: every cycle after the first reset edge.
  initial begin : compare
    int exp_data;
    exp_data = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (edge_cnt >= 1) begin
        if (rst_at.exists(edge_cnt)) exp_data = 0;
        if (pulse_at.exists(edge_cnt)) exp_data = pulse_at[edge_cnt];
        check("out_valid", int'(out_valid), int'(pulse_at.exists(edge_cnt)));
        check("out_data", int'(out_data), exp_data);
        check("busy", int'(busy), int'(busy_at.exists(edge_cnt) && busy_at[edge_cnt]));
        if (out_valid) got_q.push_back(int'(out_data));
      end
    end
  end

  int gap_pat [20] = '{1,0,1,1,0,0,1,0,1,0,1,1,0,0,0,1,0,1,0,0};

  initial begin : stim
    int k;
    int exp_lit [8];
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    idle(2);

    for (int i = 0; i < 9; i++) tap(1, 1);
    idle(4);

    for (int i = 0; i < 9; i++) tap(-128, -128);
    idle(3);
    for (int i = 0; i < 9; i++) tap(127, -128);
    idle(3);

    for (int i = 0; i < 9; i++) tap(2, 3);
    for (int i = 0; i < 9; i++) tap(1, -1);
    idle(3);

    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (gap_pat[i] == 1) begin
        tap(k, 1);
        k++;
      end else begin
        idle(1);
      end
    end
    idle(3);

    for (int i = 0; i < 5; i++) tap(3, 3);
    step(1'b0, 1'b1, 1'b1, 3, 3);
    idle(4);
    for (int i = 0; i < 9; i++) tap(1, 1);
    idle(3);

    for (int i = 0; i < 4; i++) tap(5, 5);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    idle(2);
    for (int i = 0; i < 9; i++) tap(1, 2);
    idle(4);

    done = 1'b1;
    @(negedge clk);

`ifdef CONV_MAC_RELU_EN
    exp_lit = '{9, 147456, 0, 54, 0, 36, 9, 18};
`else
    exp_lit = '{9, 147456, -146304, 54, -9, 36, 9, 18};
`endif
    check("pulse_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) check($sformatf("window_%0d", i), got_q[i], exp_lit[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_conv_window_mac
